// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - LEGv8 ID stage: register file, decode, load-use stall, ID/EX register
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   instr_id, pc_id, valid_id       instruction in ID, its PC, and whether it is real
//   flush                           branch squash from EX; loads a bubble into ID/EX
//   wb_regwrite, wb_rd, wb_data     register file write port driven from WB
//   stall_out                       load-use hazard; IF and IF/ID must hold
//   *_ex                            registered controls, register indices, operands, immediate, PC
//   stall_cnt                       saturating count of cycles stalled for load-use
//
// Optional feature: define DECODE_WB_BYPASS_EN to forward same-cycle WB writes to the read ports.
module decode_pipe_stage #(
    parameter int DATA_W      = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr_id,
    input  logic [DATA_W-1:0]      pc_id,
    input  logic                   valid_id,
    input  logic                   flush,
    input  logic                   wb_regwrite,
    input  logic [4:0]             wb_rd,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   stall_out,
    output logic                   valid_ex,
    output logic                   regwrite_ex,
    output logic                   alusrc_ex,
    output logic                   branch_ex,
    output logic                   uncondbranch_ex,
    output logic                   memread_ex,
    output logic                   memwrite_ex,
    output logic                   mem2reg_ex,
    output logic [3:0]             aluop_ex,
    output logic [4:0]             rd_ex,
    output logic [4:0]             rn_ex,
    output logic [4:0]             rm_ex,
    output logic [DATA_W-1:0]      busa_ex,
    output logic [DATA_W-1:0]      busb_ex,
    output logic [DATA_W-1:0]      imm_ex,
    output logic [DATA_W-1:0]      pc_ex,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // X31 is not stored; it always reads as zero.
    logic [DATA_W-1:0] regs [0:30];

    logic is_ldur, is_stur, is_add, is_sub, is_and, is_orr, is_cbz, is_b;
    logic is_rtype, reads_b, bubble;
    logic [4:0] rn_idx, rb_idx, rd_idx;
    logic [DATA_W-1:0] busa, busb, imm;
    logic [6:0] ctrl;   // {regwrite, alusrc, branch, uncond, memread, memwrite, mem2reg}
    logic [3:0] aluop;

    assign is_ldur  = (instr_id[31:21] == 11'h7C2);
    assign is_stur  = (instr_id[31:21] == 11'h7C0);
    assign is_add   = (instr_id[31:21] == 11'h458);
    assign is_sub   = (instr_id[31:21] == 11'h658);
    assign is_and   = (instr_id[31:21] == 11'h450);
    assign is_orr   = (instr_id[31:21] == 11'h550);
    assign is_cbz   = (instr_id[31:24] == 8'hB4);
    assign is_b     = (instr_id[31:26] == 6'h05);
    assign is_rtype = is_add | is_sub | is_and | is_orr;
    assign reads_b  = is_rtype | is_stur | is_cbz;

    // STUR and CBZ carry the register to read in the Rt field rather than Rm.
    assign rn_idx = instr_id[9:5];
    assign rb_idx = (is_stur | is_cbz) ? instr_id[4:0] : instr_id[20:16];
    assign rd_idx = instr_id[4:0];

    always_comb begin
        busa = '0;
        busb = '0;
        if (rn_idx != 5'd31) busa = regs[rn_idx];
        if (rb_idx != 5'd31) busb = regs[rb_idx];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_regwrite && (wb_rd == rn_idx) && (rn_idx != 5'd31)) busa = wb_data;
        if (wb_regwrite && (wb_rd == rb_idx) && (rb_idx != 5'd31)) busb = wb_data;
`endif
    end

    always_comb begin
        ctrl  = 7'b0;
        aluop = 4'b0000;
        if (is_ldur) begin
            ctrl  = 7'b1100101;
            aluop = 4'b0010;
        end else if (is_stur) begin
            ctrl  = 7'b0100010;
            aluop = 4'b0010;
        end else if (is_add) begin
            ctrl  = 7'b1000000;
            aluop = 4'b0010;
        end else if (is_sub) begin
            ctrl  = 7'b1000000;
            aluop = 4'b0110;
        end else if (is_and) begin
            ctrl  = 7'b1000000;
            aluop = 4'b0000;
        end else if (is_orr) begin
            ctrl  = 7'b1000000;
            aluop = 4'b0001;
        end else if (is_cbz) begin
            ctrl  = 7'b0010000;
            aluop = 4'b0111;
        end else if (is_b) begin
            ctrl  = 7'b0001000;
        end
    end

    always_comb begin
        imm = '0;
        if (is_ldur || is_stur) imm = {{(DATA_W-9){instr_id[20]}}, instr_id[20:12]};
        else if (is_cbz)        imm = {{(DATA_W-19){instr_id[23]}}, instr_id[23:5]};
        else if (is_b)          imm = {{(DATA_W-26){instr_id[25]}}, instr_id[25:0]};
    end

    // valid_ex is zero during reset, so the hazard term is already low then;
    // the explicit reset gate keeps stall_out low regardless.
    assign stall_out = ~reset & valid_id & valid_ex & memread_ex & (rd_ex != 5'd31) &
                       ((rd_ex == rn_idx) | (reads_b & (rd_ex == rb_idx)));

    assign bubble = flush | stall_out | ~valid_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 31; i++) regs[i] <= '0;
        end else if (wb_regwrite && (wb_rd != 5'd31)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_ex <= 1'b0;
            {regwrite_ex, alusrc_ex, branch_ex, uncondbranch_ex,
             memread_ex, memwrite_ex, mem2reg_ex} <= 7'b0;
            aluop_ex <= 4'b0;
            rd_ex    <= 5'd0;
            rn_ex    <= 5'd0;
            rm_ex    <= 5'd0;
            busa_ex  <= '0;
            busb_ex  <= '0;
            imm_ex   <= '0;
            pc_ex    <= '0;
        end else begin
            // Operand fields load every cycle; a bubble only needs valid and controls cleared.
            valid_ex <= ~bubble;
            {regwrite_ex, alusrc_ex, branch_ex, uncondbranch_ex,
             memread_ex, memwrite_ex, mem2reg_ex} <= bubble ? 7'b0 : ctrl;
            aluop_ex <= bubble ? 4'b0 : aluop;
            rd_ex    <= rd_idx;
            rn_ex    <= rn_idx;
            rm_ex    <= rb_idx;
            busa_ex  <= busa;
            busb_ex  <= busb;
            imm_ex   <= imm;
            pc_ex    <= pc_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_out && !flush && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb/tb_decode_pipe_stage.sv - self-checking bench for decode_pipe_stage against a table-driven reference model
module tb_decode_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_id;
    logic [63:0] pc_id;
    logic        valid_id, flush, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        stall_out, valid_ex, regwrite_ex, alusrc_ex, branch_ex, uncondbranch_ex;
    logic        memread_ex, memwrite_ex, mem2reg_ex;
    logic [3:0]  aluop_ex;
    logic [4:0]  rd_ex, rn_ex, rm_ex;
    logic [63:0] busa_ex, busb_ex, imm_ex, pc_ex;
    logic [15:0] stall_cnt;

    decode_pipe_stage #(.DATA_W(64), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id),
        .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_out(stall_out), .valid_ex(valid_ex), .regwrite_ex(regwrite_ex),
        .alusrc_ex(alusrc_ex), .branch_ex(branch_ex), .uncondbranch_ex(uncondbranch_ex),
        .memread_ex(memread_ex), .memwrite_ex(memwrite_ex), .mem2reg_ex(mem2reg_ex),
        .aluop_ex(aluop_ex), .rd_ex(rd_ex), .rn_ex(rn_ex), .rm_ex(rm_ex),
        .busa_ex(busa_ex), .busb_ex(busb_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Opcode table: mask/match, controls {regwrite,alusrc,branch,uncond,memread,memwrite,mem2reg},
    // ALU op, immediate kind (0 none, 1 D [20:12], 2 CB [23:5], 3 B [25:0]),
    // port-B field from Rt, and whether port B is a real source operand.
    localparam logic [31:0] T_MASK  [8] = '{32'hFFE00000, 32'hFFE00000, 32'hFFE00000, 32'hFFE00000,
                                            32'hFFE00000, 32'hFFE00000, 32'hFF000000, 32'hFC000000};
    localparam logic [31:0] T_MATCH [8] = '{32'hF8400000, 32'hF8000000, 32'h8B000000, 32'hCB000000,
                                            32'h8A000000, 32'hAA000000, 32'hB4000000, 32'h14000000};
    localparam logic [6:0]  T_CTRL  [8] = '{7'b1100101, 7'b0100010, 7'b1000000, 7'b1000000,
                                            7'b1000000, 7'b1000000, 7'b0010000, 7'b0001000};
    localparam logic [3:0]  T_ALU   [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0110,
                                            4'b0000, 4'b0001, 4'b0111, 4'b0000};
    localparam int          T_IMM   [8] = '{1, 1, 0, 0, 0, 0, 2, 3};
    localparam bit          T_BSEL  [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
    localparam bit          T_RDB   [8] = '{0, 1, 1, 1, 1, 1, 1, 0};

    logic [63:0] m_regs [32];
    logic        m_valid, m_memread;
    logic [4:0]  m_rd;
    int          m_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int find_op(input logic [31:0] ins);
        for (int i = 0; i < 8; i++)
            if ((ins & T_MASK[i]) == T_MATCH[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] model_imm(input int k, input logic [31:0] ins);
        longint v;
        v = 0;
        if (k >= 0) begin
            case (T_IMM[k])
                1: begin v = longint'(ins[20:12]); if (ins[20]) v -= 512;      end
                2: begin v = longint'(ins[23:5]);  if (ins[23]) v -= 524288;   end
                3: begin v = longint'(ins[25:0]);  if (ins[25]) v -= 67108864; end
                default: v = 0;
            endcase
        end
        return 64'(v);
    endfunction

    function automatic logic [63:0] model_read(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_regwrite && wb_rd == idx) return wb_data;
`endif
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_valid = 0; m_memread = 0; m_rd = 0; m_cnt = 0;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic f,
                         input logic wr, input logic [4:0] wrd, input logic [63:0] wd,
                         input logic [63:0] pc);
        instr_id = ins; valid_id = v; flush = f;
        wb_regwrite = wr; wb_rd = wrd; wb_data = wd; pc_id = pc;
    endtask

    // Entered just after a negedge with inputs applied; leaves at the next negedge.
    task automatic cycle();
        int k;
        logic [4:0] rn, rb;
        logic sb, bub;
        logic [63:0] ea, eb, ei;
        #1;
        k  = find_op(instr_id);
        rn = instr_id[9:5];
        rb = (k >= 0 && T_BSEL[k]) ? instr_id[4:0] : instr_id[20:16];
        sb = valid_id && m_valid && m_memread && m_rd != 5'd31 &&
             (m_rd == rn || (k >= 0 && T_RDB[k] && m_rd == rb));
        chk("stall_out", 64'(stall_out), 64'(sb));
        bub = flush || sb || !valid_id;
        ea = model_read(rn);
        eb = model_read(rb);
        ei = model_imm(k, instr_id);
        @(posedge clk);
        if (wb_regwrite && wb_rd != 5'd31) m_regs[wb_rd] = wb_data;
        if (sb && !flush && m_cnt < 65535) m_cnt++;
        m_valid   = !bub;
        m_memread = !bub && k >= 0 && T_CTRL[k][2];
        m_rd      = instr_id[4:0];
        #1;
        chk("valid_ex", 64'(valid_ex), 64'(!bub));
        chk("ctrl_ex", 64'({regwrite_ex, alusrc_ex, branch_ex, uncondbranch_ex,
                            memread_ex, memwrite_ex, mem2reg_ex}),
            64'((bub || k < 0) ? 7'b0 : T_CTRL[k]));
        chk("aluop_ex", 64'(aluop_ex), 64'((bub || k < 0) ? 4'b0 : T_ALU[k]));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (!bub) begin
            chk("rd_ex", 64'(rd_ex), 64'(m_rd));
            chk("rn_ex", 64'(rn_ex), 64'(rn));
            chk("rm_ex", 64'(rm_ex), 64'(rb));
            chk("busa_ex", busa_ex, ea);
            chk("busb_ex", busb_ex, eb);
            chk("imm_ex", imm_ex, ei);
            chk("pc_ex", pc_ex, pc_id);
        end
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] ins;
        model_reset();
        reset = 1'b1;
        drive(32'h0, 0, 0, 0, 0, 64'd0, 64'd0);
        #1;
        chk("reset_valid_ex", 64'(valid_ex), 64'd0);
        chk("reset_busa_ex", busa_ex, 64'd0);
        chk("reset_stall_out", 64'(stall_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Seed registers; the X31 write must be ignored.
        drive(32'h0, 0, 0, 1, 5'd2, 64'h11, 64'd0);         cycle();
        drive(32'h0, 0, 0, 1, 5'd3, 64'h22, 64'd0);         cycle();
        drive(32'h0, 0, 0, 1, 5'd5, 64'h5A5A, 64'd0);       cycle();
        drive(32'h0, 0, 0, 1, 5'd9, 64'h99, 64'd0);         cycle();
        drive(32'h0, 0, 0, 1, 5'd31, 64'hDEAD, 64'd0);      cycle();

        // ADD X1,X2,X3
        drive(32'h8B030041, 1, 0, 0, 0, 64'd0, 64'd8);      cycle();
        chk("add_busa", busa_ex, 64'h11);
        chk("add_busb", busb_ex, 64'h22);
        chk("add_pc", pc_ex, 64'd8);

        // LDUR X9 then dependent ADD: one stall, then issue
        drive(32'hF84003E9, 1, 0, 0, 0, 64'd0, 64'h10);     cycle();
        drive(32'h8B09012A, 1, 0, 0, 0, 64'd0, 64'h14);     cycle();
        chk("ldu_cnt", 64'(stall_cnt), 64'd1);
        chk("ldu_bubble", 64'(valid_ex), 64'd0);
        cycle();
        chk("ldu_issue", 64'(valid_ex), 64'd1);
        chk("ldu_issue_rd", 64'(rd_ex), 64'd10);

        // CBZ X9,#-2
        drive(32'hB4FFFFC9, 1, 0, 0, 0, 64'd0, 64'h18);     cycle();
        chk("cbz_imm", imm_ex, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("cbz_rm", 64'(rm_ex), 64'd9);

        // Flush during a load-use stall: bubble, counter unchanged
        drive(32'hF84003E9, 1, 0, 0, 0, 64'd0, 64'h20);     cycle();
        drive(32'h8B09012A, 1, 1, 0, 0, 64'd0, 64'h24);     cycle();
        chk("flush_cnt", 64'(stall_cnt), 64'd1);
        chk("flush_bubble", 64'(valid_ex), 64'd0);
        drive(32'h8B09012A, 1, 0, 0, 0, 64'd0, 64'h24);     cycle();

        // ORR X10,X9,XZR while WB writes X9
        drive(32'hAA1F012A, 1, 0, 1, 5'd9, 64'h55, 64'h28); cycle();
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_same_cycle", busa_ex, 64'h55);
`else
        chk("wb_same_cycle", busa_ex, 64'h99);
`endif

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid_ex", 64'(valid_ex), 64'd0);
        chk("areset_regwrite_ex", 64'(regwrite_ex), 64'd0);
        chk("areset_rd_ex", 64'(rd_ex), 64'd0);
        chk("areset_busa_ex", busa_ex, 64'd0);
        chk("areset_pc_ex", pc_ex, 64'd0);
        chk("areset_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("areset_stall_out", 64'(stall_out), 64'd0);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        drive(32'h8B0500A1, 1, 0, 0, 0, 64'd0, 64'h30);     cycle();
        chk("x5_after_reset", busa_ex, 64'd0);

        // Randomized traffic with a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 9))
                0, 1: ins[31:21] = 11'h7C2;
                2:    ins[31:21] = 11'h7C0;
                3:    ins[31:21] = 11'h458;
                4:    ins[31:21] = 11'h658;
                5:    ins[31:21] = 11'h450;
                6:    ins[31:21] = 11'h550;
                7:    ins[31:24] = 8'hB4;
                8:    ins[31:26] = 6'h05;
                default: ;
            endcase
            if (ins[31:26] != 6'h05) begin
                ins[4:0] = pick_reg();
                ins[9:5] = pick_reg();
                if (ins[31:24] != 8'hB4) ins[20:16] = pick_reg();
            end
            drive(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                  1'($urandom), pick_reg(), {$urandom, $urandom}, {$urandom, $urandom});
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
